// File: rtl/alu_reservation_station.sv
// Age-ordered collapsing reservation station feeding one ALU: tag wakeup, oldest-ready select, ROB kill.
// Optional build macro ALU_RS_WAKEUP_BYPASS_EN lets same-cycle wakeups count toward eligibility.
module alu_reservation_station #(
   parameter int RS_DEPTH         = 4,
   parameter int NUM_WAKEUP_PORTS = 3
) (
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic                          dispatch_valid,
   input  logic [47:0]                   dispatch_struct,
   output logic                          dispatch_ready,
   input  logic [NUM_WAKEUP_PORTS-1:0]   wakeup_valid,
   input  logic [6*NUM_WAKEUP_PORTS-1:0] wakeup_tag,
   input  logic                          kill_valid,
   input  logic [4:0]                    kill_ROB_index,
   output logic                          issue_valid,
   input  logic                          issue_ready,
   output logic [3:0]                    issue_op,
   output logic                          issue_itype,
   output logic [5:0]                    issue_source_0_tag,
   output logic [5:0]                    issue_source_1_tag,
   output logic [5:0]                    issue_dest_phys_reg_tag,
   output logic [15:0]                   issue_imm16,
   output logic [4:0]                    issue_ROB_index
);
   localparam int CNT_W = $clog2(RS_DEPTH + 1);

   typedef struct packed {
      logic [3:0]  op;
      logic        itype;
      logic        s0_needed;
      logic        s0_ready;
      logic [5:0]  s0_tag;
      logic        s1_needed;
      logic        s1_ready;
      logic [5:0]  s1_tag;
      logic [5:0]  dest;
      logic [15:0] imm16;
      logic [4:0]  rob;
   } rs_payload_t;

   typedef struct packed {
      logic        valid;
      rs_payload_t pl;
   } rs_entry_t;

   typedef struct packed {
      logic [3:0]  op;
      logic        itype;
      logic [5:0]  s0_tag;
      logic [5:0]  s1_tag;
      logic [5:0]  dest;
      logic [15:0] imm16;
      logic [4:0]  rob;
   } issue_t;

   function automatic logic tag_hit(input logic [5:0] tag,
                                    input logic [NUM_WAKEUP_PORTS-1:0] vld,
                                    input logic [6*NUM_WAKEUP_PORTS-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < NUM_WAKEUP_PORTS; p++)
         if (vld[p] && tags[6*p +: 6] == tag) hit = 1'b1;
      return hit;
   endfunction

   rs_entry_t           ent_q [RS_DEPTH];
   rs_entry_t           ent_d [RS_DEPTH];
   logic [CNT_W-1:0]    count_q, count_d;
   issue_t              issue_q, issue_d;
   logic                issue_valid_q, issue_valid_d;
   rs_payload_t         disp_pl;
   logic                accept, issue_free, sel_valid;
   logic [RS_DEPTH-1:0] rdy0_w, rdy1_w, elig, killed, sel_oh;
   issue_t              sel_iss;

   assign disp_pl        = rs_payload_t'(dispatch_struct);
   assign dispatch_ready = count_q < CNT_W'(RS_DEPTH);
   assign accept         = dispatch_valid && dispatch_ready;
   assign issue_free     = !issue_valid_q || issue_ready;

   generate
      for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_ent
         // Ready bits with this cycle's wakeups folded in; these are what get written back.
         assign rdy0_w[gi] = ent_q[gi].pl.s0_ready |
                             (ent_q[gi].pl.s0_needed & tag_hit(ent_q[gi].pl.s0_tag, wakeup_valid, wakeup_tag));
         assign rdy1_w[gi] = ent_q[gi].pl.s1_ready |
                             (ent_q[gi].pl.s1_needed & tag_hit(ent_q[gi].pl.s1_tag, wakeup_valid, wakeup_tag));
`ifdef ALU_RS_WAKEUP_BYPASS_EN
         assign elig[gi] = ent_q[gi].valid && (!ent_q[gi].pl.s0_needed || rdy0_w[gi]) &&
                           (!ent_q[gi].pl.s1_needed || rdy1_w[gi]);
`else
         assign elig[gi] = ent_q[gi].valid && (!ent_q[gi].pl.s0_needed || ent_q[gi].pl.s0_ready) &&
                           (!ent_q[gi].pl.s1_needed || ent_q[gi].pl.s1_ready);
`endif
         assign killed[gi] = kill_valid && ent_q[gi].valid && (ent_q[gi].pl.rob == kill_ROB_index);
      end
   endgenerate

   always_comb begin
      sel_oh    = '0;
      sel_valid = 1'b0;
      sel_iss   = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (issue_free && !sel_valid && elig[i] && !killed[i]) begin
            sel_valid = 1'b1;
            sel_oh[i] = 1'b1;
            sel_iss   = '{op: ent_q[i].pl.op, itype: ent_q[i].pl.itype, s0_tag: ent_q[i].pl.s0_tag,
                          s1_tag: ent_q[i].pl.s1_tag, dest: ent_q[i].pl.dest,
                          imm16: ent_q[i].pl.imm16, rob: ent_q[i].pl.rob};
         end
      end
   end

   // Survivors pack down in order; the new dispatch lands right behind them.
   always_comb begin
      rs_entry_t e;
      int        wptr;
      wptr = 0;
      e    = '0;
      for (int k = 0; k < RS_DEPTH; k++) ent_d[k] = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         e             = ent_q[i];
         e.pl.s0_ready = rdy0_w[i];
         e.pl.s1_ready = rdy1_w[i];
         if (e.valid && !killed[i] && !sel_oh[i]) begin
            for (int k = 0; k < RS_DEPTH; k++)
               if (k == wptr) ent_d[k] = e;
            wptr++;
         end
      end
      if (accept) begin
         e.valid       = 1'b1;
         e.pl          = disp_pl;
         e.pl.s0_ready = disp_pl.s0_ready |
                         (disp_pl.s0_needed & tag_hit(disp_pl.s0_tag, wakeup_valid, wakeup_tag));
         e.pl.s1_ready = disp_pl.s1_ready |
                         (disp_pl.s1_needed & tag_hit(disp_pl.s1_tag, wakeup_valid, wakeup_tag));
         for (int k = 0; k < RS_DEPTH; k++)
            if (k == wptr) ent_d[k] = e;
         wptr++;
      end
      count_d = CNT_W'(wptr);
   end

   always_comb begin
      issue_valid_d = issue_valid_q;
      issue_d       = issue_q;
      if (sel_valid) begin
         issue_valid_d = 1'b1;
         issue_d       = sel_iss;
      end else if (issue_valid_q && issue_ready) begin
         issue_valid_d = 1'b0;
      end else if (issue_valid_q && kill_valid && issue_q.rob == kill_ROB_index) begin
         issue_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q       <= '0;
         issue_valid_q <= 1'b0;
         issue_q       <= '0;
         for (int k = 0; k < RS_DEPTH; k++) ent_q[k] <= '0;
      end else begin
         count_q       <= count_d;
         issue_valid_q <= issue_valid_d;
         issue_q       <= issue_d;
         for (int k = 0; k < RS_DEPTH; k++) ent_q[k] <= ent_d[k];
      end
   end

   assign issue_valid             = issue_valid_q;
   assign issue_op                = issue_q.op;
   assign issue_itype             = issue_q.itype;
   assign issue_source_0_tag      = issue_q.s0_tag;
   assign issue_source_1_tag      = issue_q.s1_tag;
   assign issue_dest_phys_reg_tag = issue_q.dest;
   assign issue_imm16             = issue_q.imm16;
   assign issue_ROB_index         = issue_q.rob;
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Consumer end of the dispatch→ALU interface. Accepts ALU_RS_input_struct_t packets from dispatch and holds them in an age-ordered collapsing queue.
- Wakes up source operands by snooping physical-register writeback tags.
- Issues the oldest fully-ready entry to one ALU pipeline through a registered valid/ready output stage.
- Removes entries on ROB kill jobs. One instance sits in front of each of ALU 0 and ALU 1.

Parameters:
- RS_DEPTH, 4: number of queue entries; entry 0 is the oldest.
- NUM_WAKEUP_PORTS, 3: number of writeback tag buses snooped (ALU 0, ALU 1, LQ).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- dispatch_valid  in  1  dispatch presents a packet
- dispatch_struct  in  48  ALU_RS_input_struct_t {op[3:0], itype, source_0{needed,ready,tag[5:0]}, source_1{same}, dest_phys_reg_tag[5:0], imm16[15:0], ROB_index[4:0]}
- dispatch_ready  out  1  RS can accept a packet this cycle
- wakeup_valid  in  NUM_WAKEUP_PORTS  per-port writeback valid
- wakeup_tag  in  6*NUM_WAKEUP_PORTS  per-port phys_reg_tag_t; port i occupies [6i+5:6i]
- kill_valid  in  1  ROB kill job valid
- kill_ROB_index  in  5  ROB_index_t to kill, full 5-bit compare
- issue_valid  out  1  issue register holds an instruction
- issue_ready  in  1  ALU accepts the instruction this cycle
- issue_op  out  4  ALU_op_t
- issue_itype  out  1
- issue_source_0_tag  out  6
- issue_source_1_tag  out  6
- issue_dest_phys_reg_tag  out  6
- issue_imm16  out  16
- issue_ROB_index  out  5

Behaviour:
- Reset (nRST low, asynchronous): all entry valids = 0; count = 0; issue_valid = 0; all issue_* data outputs = 0; dispatch_ready = 1 once out of reset.
- dispatch_ready is 1 when count < RS_DEPTH, using the registered count. Slots freed in the same cycle do not raise it.
- dispatch_valid while dispatch_ready = 0 is ignored and causes no state change.
- Accepted dispatch:
  - Written at the first free slot after the current cycle's removals have been compacted, so queue order equals dispatch order.
  - On insert, a source's ready bit = struct ready OR (needed AND any valid wakeup tag equals the source tag this cycle). A same-cycle wakeup must not be lost.
- Wakeup: every valid entry compares each needed source tag against all valid wakeup ports every cycle. A match sets that source's ready bit. Ready bits never clear.
- Entry eligibility = valid AND (!needed OR ready) for both sources, using registered bits.
- Select:
  - Picks the lowest-index eligible entry that is not being killed this cycle.
  - Selects only if the issue register is empty, or is being consumed (issue_valid AND issue_ready).
  - The selected entry moves into the issue register at the next edge and leaves the queue.
- Issue register hold: while issue_valid = 1 and issue_ready = 0, all issue_* outputs are held stable.
- Latency, dispatch to issue_valid: 2 cycles with all sources ready at dispatch.
  - Cycle N: accepted.
  - Cycle N+1: eligible and selected.
  - Cycle N+2: issue_valid = 1.
- Kill:
  - kill_valid removes any queue entry whose ROB_index equals kill_ROB_index.
  - Kill has priority over select.
  - If the issue register holds the matching ROB_index and is not consumed this cycle, issue_valid clears next cycle.
  - If it is consumed this cycle, the handoff completes and the kill has no effect on it.
  - Kill compares only against existing entries, never against the same-cycle dispatch.
- Compaction: up to 2 removals per cycle (select + kill of different entries). Surviving entries shift down and preserve relative order.
- count_next = count + accepted dispatch − removals. count must never exceed RS_DEPTH or underflow.
- Reset asserted mid-operation drops all entries and the issue register immediately.

Optional Feature:
- Macro: ALU_RS_WAKEUP_BYPASS_EN.
- Defined: eligibility also counts this cycle's wakeup matches for entries already in the queue. A wakeup at cycle N gives issue_valid at N+1.
- Undefined: eligibility uses registered ready bits only. A wakeup at cycle N gives issue_valid at N+2.
- Dispatch-time capture of same-cycle wakeups applies in both builds.

Test Plan:
- Ready issue: dispatch ADD, both sources ready, ROB 3, issue_ready = 1 → issue_valid = 1 exactly 2 cycles later with issue_ROB_index = 3 and the dispatched tags and imm16.
- Wakeup ordering:
  - Stimulus: dispatch A (ROB 1, source_0 tag 12 not ready), then B (ROB 2, all ready), then pulse wakeup port 1 with tag 12.
  - Required: B issues first, then A.
  - Required: with the bypass macro off, A's issue_valid appears 2 cycles after the wakeup.
- Full/backpressure:
  - Stimulus: hold issue_ready = 0 and dispatch 5 ready packets.
  - Required: 1 is held in the issue register, dispatch_ready = 0 once 4 are queued, the further dispatch attempt is ignored, and the outputs stay stable.
  - Then: set issue_ready = 1 → all drain in dispatch order.
- Kill: queue ROB 4, 5, 6 (non-ready), kill 5 → entries 4 and 6 remain compacted in order. Wake them → issue order is 4, 6; 5 never issues.
- Dispatch/wakeup race: dispatch source_1 tag 40 not ready in the same cycle as wakeup port 0 tag 40 → the entry issues without any further wakeup.
- Async reset: assert nRST low mid-drain with issue_valid = 1 → issue_valid = 0 immediately, count = 0, dispatch_ready = 1 after release.
